// File: rtl/scanline_reader.sv
// Display-side reader for the two-bank packed line buffer: prefetches during
// horizontal blank, unpacks 4-bit color indices and handshakes bank ownership.
module scanline_reader #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_TOTAL  = 800,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_TOTAL  = 525,
   parameter logic [3:0]  BG_INDEX = 4'h4
) (
   input  logic        Clk50,
   input  logic        Reset,
   input  logic        pixel_en,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic        rd_en,
   output logic [8:0]  rd_addr,
   input  logic [15:0] rd_data,
   input  logic        line_ready,
   output logic        line_release,
   output logic        read_bank,
   output logic [3:0]  color_index,
   output logic [7:0]  underrun_count
);

   localparam int unsigned WORDS = H_ACTIVE / 4;

   typedef enum logic [1:0] {IDLE, PRE1, PRE2, ACTIVE} state_t;

   state_t      state;
   logic [15:0] cur_word;
   logic [15:0] nxt_word;
   logic        fetched;
   logic        cap_nxt;

   logic        line_start;
   logic [9:0]  next_row;
   logic        visible;
   logic        in_line;
   logic [8:0]  word_fetch;
   logic [3:0]  nib;

   assign line_start = pixel_en && (DrawX == 10'(H_TOTAL - 1));
   assign next_row   = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
   assign visible    = (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
   assign in_line    = (state == PRE2) || (state == ACTIVE);
   // Word two ahead of the one being displayed; cur/nxt already hold the next two.
   assign word_fetch = 9'(DrawX[9:2]) + 9'd2;

   // Leftmost pixel lives in the top nibble.
   always_comb begin
      nib = cur_word[3:0];
      case (DrawX[1:0])
         2'd0:    nib = cur_word[15:12];
         2'd1:    nib = cur_word[11:8];
         2'd2:    nib = cur_word[7:4];
         default: nib = cur_word[3:0];
      endcase
   end

   always_ff @(posedge Clk50) begin
      if (Reset) begin
         state          <= IDLE;
         rd_en          <= 1'b0;
         rd_addr        <= '0;
         line_release   <= 1'b0;
         read_bank      <= 1'b0;
         color_index    <= '0;
         underrun_count <= '0;
         cur_word       <= '0;
         nxt_word       <= '0;
         fetched        <= 1'b0;
         cap_nxt        <= 1'b0;
      end else begin
         rd_en        <= 1'b0;
         line_release <= 1'b0;
         cap_nxt      <= 1'b0;
         if (cap_nxt) nxt_word <= rd_data;

         if (pixel_en) begin
            if (!visible)     color_index <= '0;
            else if (in_line) color_index <= fetched ? nib : BG_INDEX;
            else              color_index <= '0;
         end

         // A line start always wins, aborting any line still in progress.
         if (line_start) begin
            state <= IDLE;
            if (next_row < 10'(V_ACTIVE)) begin
               if (line_ready) begin
                  fetched <= 1'b1;
                  rd_en   <= 1'b1;
                  rd_addr <= {read_bank, 8'd0};
                  state   <= PRE1;
               end else begin
                  fetched <= 1'b0;
                  if (underrun_count != 8'hFF) underrun_count <= underrun_count + 8'd1;
                  state   <= ACTIVE;
               end
            end
         end else begin
            case (state)
               PRE1: begin
                  cur_word <= rd_data;
                  rd_en    <= 1'b1;
                  rd_addr  <= {read_bank, 8'd1};
                  state    <= PRE2;
               end
               PRE2, ACTIVE: begin
                  // Pixel 0 may already arrive while word 1 is landing.
                  if (state == PRE2) begin
                     nxt_word <= rd_data;
                     state    <= ACTIVE;
                  end
                  if (pixel_en && (DrawX < 10'(H_ACTIVE))) begin
                     if (fetched && (DrawX[1:0] == 2'd3)) begin
                        cur_word <= nxt_word;
                        if (word_fetch < 9'(WORDS)) begin
                           rd_en   <= 1'b1;
                           rd_addr <= {read_bank, word_fetch[7:0]};
                           cap_nxt <= 1'b1;
                        end
                     end
                     if (DrawX == 10'(H_ACTIVE - 1)) begin
                        if (fetched) begin
                           line_release <= 1'b1;
                           read_bank    <= ~read_bank;
                        end
                        state <= IDLE;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_scanline_reader.sv
// Directed bench for scanline_reader: a line-level reference model is checked
// every cycle, with hand-computed literals pinning the model.
module tb_scanline_reader;

   localparam int H_ACTIVE = 640;
   localparam int H_TOTAL  = 800;
   localparam int V_ACTIVE = 480;
   localparam int V_TOTAL  = 525;
   localparam int WORDS    = 160;

   logic        Clk50 = 1'b0;
   logic        Reset = 1'b0;
   logic        pixel_en = 1'b0;
   logic [9:0]  DrawX = '0;
   logic [9:0]  DrawY = '0;
   logic        line_ready = 1'b0;
   logic        rd_en;
   logic [8:0]  rd_addr;
   logic [15:0] rd_data;
   logic        line_release;
   logic        read_bank;
   logic [3:0]  color_index;
   logic [7:0]  underrun_count;

   logic [15:0] mem [0:511];
   assign rd_data = rd_en ? mem[rd_addr] : 16'hDEAD;

   always #5 Clk50 = ~Clk50;

   scanline_reader dut (
      .Clk50(Clk50), .Reset(Reset), .pixel_en(pixel_en), .DrawX(DrawX), .DrawY(DrawY),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .line_ready(line_ready),
      .line_release(line_release), .read_bank(read_bank), .color_index(color_index),
      .underrun_count(underrun_count)
   );

   int n_chk = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;

   // Reference model state
   int exp_color, exp_bank, exp_ucount, exp_release;
   bit m_in_line, m_fetched;
   int m_lbank;
   bit seen [256];
   int rd_log [$];
   int last_rel;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_nib(input int bank, input int x);
      logic [15:0] w;
      w = mem[bank * 256 + x / 4];
      return int'((w >> (4 * (3 - x % 4))) & 16'hF);
   endfunction

   task automatic model_reset();
      exp_color = 0; exp_bank = 0; exp_ucount = 0; exp_release = 0;
      m_in_line = 1'b0; m_fetched = 1'b0; m_lbank = 0;
   endtask

   task automatic model_pixel(input int x, input int y);
      int nr;
      if (x == H_TOTAL - 1) begin
         nr = (y == V_TOTAL - 1) ? 0 : y + 1;
         rd_log.delete();
         foreach (seen[i]) seen[i] = 1'b0;
         exp_color = 0;
         if (nr < V_ACTIVE) begin
            m_in_line = 1'b1;
            m_fetched = line_ready;
            m_lbank   = exp_bank;
            if (!line_ready && exp_ucount < 255) exp_ucount++;
         end else begin
            m_in_line = 1'b0;
         end
      end else if (x < H_ACTIVE && y < V_ACTIVE) begin
         if (m_in_line) begin
            exp_color = m_fetched ? exp_nib(m_lbank, x) : 4;
            if (x == H_ACTIVE - 1) begin
               if (m_fetched) begin
                  exp_release = 1;
                  exp_bank    = exp_bank ^ 1;
               end
               m_in_line = 1'b0;
            end
         end else begin
            exp_color = 0;
         end
      end else begin
         exp_color = 0;
      end
   endtask

   // Per-cycle comparison against the model, run just after each rising edge.
   task automatic compare();
      int w;
      bit ok;
      if (!chk_on) return;
      chk("color_index", int'(color_index), exp_color);
      chk("read_bank", int'(read_bank), exp_bank);
      chk("underrun_count", int'(underrun_count), exp_ucount);
      chk("line_release", int'(line_release), exp_release);
      if (rd_en) begin
         w  = int'(rd_addr[7:0]);
         ok = m_in_line && m_fetched && (int'(rd_addr[8]) == m_lbank) && (w < WORDS) && !seen[w];
         chk("rd_legal", int'(ok), 1);
         seen[w] = 1'b1;
         rd_log.push_back(int'(rd_addr));
      end
   endtask

   task automatic step();
      @(posedge Clk50);
      #1;
      compare();
      @(negedge Clk50);
   endtask

   task automatic pix(input int x, input int y);
      pixel_en = 1'b1;
      DrawX    = 10'(x);
      DrawY    = 10'(y);
      model_pixel(x, y);
      step();
      last_rel    = int'(line_release);
      pixel_en    = 1'b0;
      exp_release = 0;
      step();
   endtask

   task automatic run(input int y, input int x0, input int x1);
      for (int x = x0; x <= x1; x++) pix(x, y);
   endtask

   function automatic int log_at(input int i);
      return (i < rd_log.size()) ? rd_log[i] : -1;
   endfunction

   initial begin
      #50_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      mem[0] = 16'h1234;
      mem[1] = 16'h5678;
      for (int i = 2; i < 256; i++) mem[i] = (i < WORDS) ? 16'(i * 40503 + 7) : 16'hBEEF;
      for (int i = 0; i < 256; i++) mem[256 + i] = (i < WORDS) ? (16'(i * 12345) ^ 16'hA5C3) : 16'hBEEF;
      last_rel = 0;
      @(negedge Clk50);

      // Reset
      Reset = 1'b1; chk_on = 1'b1; model_reset();
      step(); step();
      Reset = 1'b0;
      chk("rst_color", int'(color_index), 0);
      chk("rst_bank", int'(read_bank), 0);
      chk("rst_ucount", int'(underrun_count), 0);

      // Fetched line from bank 0
      line_ready = 1'b1;
      pix(799, 0);
      for (int x = 0; x < 8; x++) begin
         pix(x, 1);
         chk("t1_idx", int'(color_index), x + 1);
      end
      run(1, 8, 639);
      chk("t1_rel_pulse", last_rel, 1);
      chk("t1_rel_low", int'(line_release), 0);
      chk("t1_addr0", log_at(0), 0);
      chk("t1_addr1", log_at(1), 1);
      chk("t1_nreads", rd_log.size(), 160);
      chk("t1_bank", int'(read_bank), 1);

      // Next line reads bank 1
      pix(799, 1);
      run(2, 0, 639);
      chk("t2_addr_first", log_at(0), 32'h100);
      chk("t2_addr_last", log_at(159), 32'h19F);
      chk("t2_nreads", rd_log.size(), 160);
      chk("t2_bank", int'(read_bank), 0);

      // Underrun line, then saturation
      line_ready = 1'b0;
      pix(799, 2);
      run(3, 0, 10);
      chk("t3_bg", int'(color_index), 4);
      run(3, 11, 639);
      chk("t3_no_rel", last_rel, 0);
      chk("t3_nreads", rd_log.size(), 0);
      chk("t3_bank", int'(read_bank), 0);
      chk("t3_ucount", int'(underrun_count), 1);
      for (int i = 0; i < 300; i++) pix(799, 5);
      chk("t3_ucount_sat", int'(underrun_count), 255);

      // line_ready drops mid-line
      line_ready = 1'b1;
      pix(799, 3);
      run(4, 0, 99);
      line_ready = 1'b0;
      run(4, 100, 639);
      chk("t4_rel_pulse", last_rel, 1);
      chk("t4_nreads", rd_log.size(), 160);
      chk("t4_bank", int'(read_bank), 1);

      // Reset mid-line
      line_ready = 1'b1;
      pix(799, 4);
      run(5, 0, 320);
      Reset = 1'b1; model_reset();
      step();
      chk("t5_rst_color", int'(color_index), 0);
      chk("t5_rst_bank", int'(read_bank), 0);
      chk("t5_rst_rel", int'(line_release), 0);
      chk("t5_rst_ucount", int'(underrun_count), 0);
      Reset = 1'b0;
      step();
      run(5, 321, 639);
      chk("t5_no_rel", last_rel, 0);
      pix(799, 5);
      chk("t5_addr0", log_at(0), 0);
      run(6, 0, 639);
      chk("t5_bank", int'(read_bank), 1);

      // Blank regions, last row and wrap to row 0
      pix(700, 10);
      chk("t6_hblank", int'(color_index), 0);
      pix(5, 490);
      chk("t6_vblank", int'(color_index), 0);
      pix(799, 478);
      chk("t6_lastrow_addr0", log_at(0), 32'h100);
      run(479, 0, 639);
      chk("t6_lastrow_rel", last_rel, 1);
      chk("t6_lastrow_bank", int'(read_bank), 0);
      pix(799, 479);
      repeat (4) step();
      chk("t6_no_start", rd_log.size(), 0);
      pix(799, 524);
      chk("t6_wrap_addr0", log_at(0), 0);
      for (int x = 0; x < 8; x++) begin
         pix(x, 0);
         chk("t6_idx", int'(color_index), x + 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
